// File: rtl/dct_dma_pkg.sv
// ============================================================================
// Module      : dct_dma_pkg
// Description : Shared types for the DCT tile DMA scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dct_dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src_base;
    logic [DMA_ADDR_W-1:0] dst_base;
    logic [DMA_ADDR_W-1:0] tile_bytes;
    logic [DMA_ADDR_W-1:0] src_stride;
    logic [DMA_ADDR_W-1:0] dst_stride;
    logic [DMA_CNT_W-1:0]  num_tiles;
  } batch_desc_t;

endpackage

`default_nettype wire

// File: rtl/dma_tile_addr_gen.sv
// ============================================================================
// Module      : dma_tile_addr_gen
// Description : Per-tile RDMA/WDMA pointer generation (base + accumulated stride).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_tile_addr_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] src_base_i,
  input  logic [ADDR_WIDTH-1:0] dst_base_i,
  input  logic [ADDR_WIDTH-1:0] src_stride_i,
  input  logic [ADDR_WIDTH-1:0] dst_stride_i,
  output logic [ADDR_WIDTH-1:0] src_ptr_o,
  output logic [ADDR_WIDTH-1:0] dst_ptr_o
);

  logic [ADDR_WIDTH-1:0] src_off_q, src_off_d;
  logic [ADDR_WIDTH-1:0] dst_off_q, dst_off_d;

  always_comb begin
    src_off_d = src_off_q;
    dst_off_d = dst_off_q;
    if (load_i) begin
      src_off_d = '0;
      dst_off_d = '0;
    end else if (step_i) begin
      // Address arithmetic wraps at 2^ADDR_WIDTH; the carry is dropped.
      src_off_d = src_off_q + src_stride_i;
      dst_off_d = dst_off_q + dst_stride_i;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      src_off_q <= '0;
      dst_off_q <= '0;
    end else begin
      src_off_q <= src_off_d;
      dst_off_q <= dst_off_d;
    end
  end

  assign src_ptr_o = src_base_i + src_off_q;
  assign dst_ptr_o = dst_base_i + dst_off_q;

endmodule

`default_nettype wire

// File: rtl/dma_tile_scheduler.sv
// ============================================================================
// Module      : dma_tile_scheduler
// Description : Launches the RDMA/WDMA wrapper once per tile of a batch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_tile_scheduler
  import dct_dma_pkg::*;
#(
  parameter int ADDR_WIDTH     = DMA_ADDR_W,
  parameter int CNT_WIDTH      = DMA_CNT_W,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  cmd_start,
  input  logic                  cmd_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_src_base,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
  input  logic [ADDR_WIDTH-1:0] cfg_tile_bytes,
  input  logic [ADDR_WIDTH-1:0] cfg_src_stride,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_num_tiles,
  output logic                  dma_ap_start,
  output logic [ADDR_WIDTH-1:0] dma_rdma_mem_ptr,
  output logic [ADDR_WIDTH-1:0] dma_rdma_transfer_byte,
  output logic [ADDR_WIDTH-1:0] dma_wdma_mem_ptr,
  output logic [ADDR_WIDTH-1:0] dma_wdma_transfer_byte,
  input  logic                  dma_ap_done,
  output logic                  busy,
  output logic                  batch_done,
  output logic                  aborted,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  tiles_done
);

  localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST =
      c_TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  sched_state_e         state_q, state_d;
  batch_desc_t          desc_q, desc_d;
  logic [CNT_WIDTH-1:0] tiles_done_q, tiles_done_d;
  logic                 aborted_q, aborted_d;
  logic                 timeout_q, timeout_d;
  logic                 abort_pend_q, abort_pend_d;
  logic [c_TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic                 w_addr_load, w_addr_step, w_abort;

  assign w_abort = abort_pend_q | cmd_abort;

  always_comb begin
    state_d      = state_q;
    desc_d       = desc_q;
    tiles_done_d = tiles_done_q;
    aborted_d    = aborted_q;
    timeout_d    = timeout_q;
    to_cnt_d     = to_cnt_q;
    w_addr_load  = 1'b0;
    w_addr_step  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          aborted_d    = 1'b0;
          timeout_d    = 1'b0;
          tiles_done_d = '0;
          if (cfg_num_tiles == '0 || cfg_tile_bytes == '0) begin
            state_d = FINISH;
          end else begin
            // Descriptor only reloads on a real launch, so an empty batch
            // leaves the pointer/byte outputs untouched.
            desc_d = '{src_base:   cfg_src_base,
                       dst_base:   cfg_dst_base,
                       tile_bytes: cfg_tile_bytes,
                       src_stride: cfg_src_stride,
                       dst_stride: cfg_dst_stride,
                       num_tiles:  cfg_num_tiles};
            w_addr_load = 1'b1;
            to_cnt_d    = '0;
            state_d     = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        to_cnt_d = to_cnt_q + c_TO_W'(1);
        state_d  = WAIT;
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + c_TO_W'(1);
        // to_cnt_q holds cycles elapsed since the start strobe.
        if (dma_ap_done) begin
          tiles_done_d = tiles_done_q + CNT_WIDTH'(1);
          state_d      = NEXT;
        end else if (TIMEOUT_CYCLES != 0 && to_cnt_q >= c_TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = FINISH;
        end
      end
      NEXT: begin
        if (tiles_done_q == desc_q.num_tiles || w_abort) begin
          aborted_d = aborted_q | w_abort;
          state_d   = FINISH;
        end else begin
          w_addr_step = 1'b1;
          to_cnt_d    = '0;
          state_d     = LAUNCH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    abort_pend_d = abort_pend_q | (cmd_abort && state_q != IDLE);
    if (state_d == IDLE) begin
      abort_pend_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= IDLE;
      desc_q       <= '0;
      tiles_done_q <= '0;
      aborted_q    <= 1'b0;
      timeout_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      tiles_done_q <= tiles_done_d;
      aborted_q    <= aborted_d;
      timeout_q    <= timeout_d;
      abort_pend_q <= abort_pend_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  dma_tile_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .ap_clk       (ap_clk),
    .areset       (areset),
    .load_i       (w_addr_load),
    .step_i       (w_addr_step),
    .src_base_i   (desc_d.src_base),
    .dst_base_i   (desc_d.dst_base),
    .src_stride_i (desc_q.src_stride),
    .dst_stride_i (desc_q.dst_stride),
    .src_ptr_o    (dma_rdma_mem_ptr),
    .dst_ptr_o    (dma_wdma_mem_ptr)
  );

  assign dma_ap_start           = (state_q == LAUNCH);
  assign dma_rdma_transfer_byte = desc_q.tile_bytes;
  assign dma_wdma_transfer_byte = desc_q.tile_bytes;
  assign busy                   = (state_q != IDLE);
  assign batch_done             = (state_q == FINISH);
  assign aborted                = aborted_q;
  assign timeout_err            = timeout_q;
  assign tiles_done             = tiles_done_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_tile_scheduler.sv
// ============================================================================
// Module      : tb_dma_tile_scheduler
// Description : Scoreboard bench for dma_tile_scheduler with a batch-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_tile_scheduler;

  localparam int AW = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          ap_clk = 1'b0;
  logic          areset;
  logic          cmd_start, cmd_abort, dma_ap_done;
  logic [AW-1:0] cfg_src_base, cfg_dst_base, cfg_tile_bytes, cfg_src_stride, cfg_dst_stride;
  logic [CW-1:0] cfg_num_tiles;
  logic          dma_ap_start, busy, batch_done, aborted, timeout_err;
  logic [AW-1:0] dma_rdma_mem_ptr, dma_rdma_transfer_byte, dma_wdma_mem_ptr, dma_wdma_transfer_byte;
  logic [CW-1:0] tiles_done;

  always #5 ap_clk = ~ap_clk;

  dma_tile_scheduler #(
    .ADDR_WIDTH (AW),
    .CNT_WIDTH (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .ap_clk (ap_clk),
    .areset (areset),
    .cmd_start (cmd_start),
    .cmd_abort (cmd_abort),
    .cfg_src_base (cfg_src_base),
    .cfg_dst_base (cfg_dst_base),
    .cfg_tile_bytes (cfg_tile_bytes),
    .cfg_src_stride (cfg_src_stride),
    .cfg_dst_stride (cfg_dst_stride),
    .cfg_num_tiles (cfg_num_tiles),
    .dma_ap_start (dma_ap_start),
    .dma_rdma_mem_ptr (dma_rdma_mem_ptr),
    .dma_rdma_transfer_byte (dma_rdma_transfer_byte),
    .dma_wdma_mem_ptr (dma_wdma_mem_ptr),
    .dma_wdma_transfer_byte (dma_wdma_transfer_byte),
    .dma_ap_done (dma_ap_done),
    .busy (busy),
    .batch_done (batch_done),
    .aborted (aborted),
    .timeout_err (timeout_err),
    .tiles_done (tiles_done)
  );

  typedef struct { logic [AW-1:0] rptr; logic [AW-1:0] wptr; logic [AW-1:0] bytes; } launch_t;
  typedef struct { int tiles; bit ab; bit to; } status_t;

  launch_t exp_launch_q[$];
  status_t exp_stat_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired, got no event, want event", nm);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a start or a batch end.
  initial begin : monitor
    launch_t e;
    status_t s;
    bit prev_start = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!areset) begin
        if (dma_ap_start) begin
          chk("start_single_cycle", prev_start, 0);
          chk("start_expected", exp_launch_q.size() > 0, 1);
          if (exp_launch_q.size() > 0) begin
            e = exp_launch_q.pop_front();
            chk("rdma_ptr", dma_rdma_mem_ptr, e.rptr);
            chk("wdma_ptr", dma_wdma_mem_ptr, e.wptr);
            chk("rdma_bytes", dma_rdma_transfer_byte, e.bytes);
            chk("wdma_bytes", dma_wdma_transfer_byte, e.bytes);
          end
        end
        if (batch_done) begin
          chk("batch_end_expected", exp_stat_q.size() > 0, 1);
          chk("busy_in_finish", busy, 1);
          if (exp_stat_q.size() > 0) begin
            s = exp_stat_q.pop_front();
            chk("tiles_done", tiles_done, s.tiles);
            chk("aborted", aborted, s.ab);
            chk("timeout_err", timeout_err, s.to);
          end
        end
      end
      prev_start = dma_ap_start;
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dma_ap_start) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    bound_fail("wait_start");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      tick();
    end
    bound_fail("wait_idle");
  endtask

  // Reference model: a batch launches min(n, abort_tile) tiles at base + i*stride
  // (32-bit wrap); an unanswered tile ends the batch with a timeout.
  task automatic run_batch(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [AW-1:0] bytes, input logic [AW-1:0] ss,
                           input logic [AW-1:0] ds, input int n, input int abort_tile,
                           input int delay, input bit inject_start, input bit hang);
    bit empty = (n == 0) || (bytes == 0);
    int ntiles = (abort_tile != 0) ? abort_tile : n;
    bit ok;
    int c;
    if (empty) begin
      exp_stat_q.push_back('{0, 1'b0, 1'b0});
    end else if (hang) begin
      exp_launch_q.push_back('{src, dst, bytes});
      exp_stat_q.push_back('{0, 1'b0, 1'b1});
    end else begin
      for (int i = 0; i < ntiles; i++)
        exp_launch_q.push_back('{src + ss * 32'(i), dst + ds * 32'(i), bytes});
      exp_stat_q.push_back('{ntiles, abort_tile != 0, 1'b0});
    end

    cfg_src_base = src; cfg_dst_base = dst; cfg_tile_bytes = bytes;
    cfg_src_stride = ss; cfg_dst_stride = ds; cfg_num_tiles = CW'(n);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;

    if (empty) begin
      chk("empty_batch_done_next_cycle", batch_done, 1);
    end else if (hang) begin
      wait_start(ok);
      if (ok) begin
        c = 0;
        while (!timeout_err && c < 40) begin
          tick();
          c++;
        end
        chk("timeout_latency", c, TO);
      end
    end else begin
      for (int t = 1; t <= ntiles; t++) begin
        wait_start(ok);
        if (!ok) break;
        for (int k = 1; k <= delay; k++) begin
          tick();
          cmd_abort   = (t == abort_tile) && (k == 1);
          cmd_start   = inject_start && (t == 1) && (k == 1);
          dma_ap_done = (k == delay);
          if (cmd_start) begin
            cfg_src_base = ~src; cfg_dst_base = ~dst; cfg_src_stride = ss + 32'h100;
            cfg_num_tiles = CW'(n + 3);
          end
        end
        tick();
        cmd_abort = 1'b0; cmd_start = 1'b0; dma_ap_done = 1'b0;
      end
    end
    wait_idle();
    tick();
    chk("busy_low_after_batch", busy, 0);
  endtask

  initial begin : main
    bit ok;
    areset = 1'b1;
    cmd_start = 1'b0; cmd_abort = 1'b0; dma_ap_done = 1'b0;
    cfg_src_base = '0; cfg_dst_base = '0; cfg_tile_bytes = '0;
    cfg_src_stride = '0; cfg_dst_stride = '0; cfg_num_tiles = '0;
    repeat (3) tick();
    areset = 1'b0;
    chk("rst_start", dma_ap_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_tiles_done", tiles_done, 0);
    chk("rst_ptrs", {dma_rdma_mem_ptr, dma_wdma_mem_ptr}, 0);
    chk("rst_bytes", {dma_rdma_transfer_byte, dma_wdma_transfer_byte}, 0);

    run_batch(32'h1000, 32'h8000, 32, 32, 64, 3, 0, 5, 0, 0);
    run_batch(32'h1000, 32'h8000, 32, 32, 64, 0, 0, 5, 0, 0);
    run_batch(32'h4000, 32'h9000, 32, 32, 32, 4, 2, 5, 0, 0);
    run_batch(32'h5000, 32'hA000, 16, 16, 16, 2, 0, 0, 0, 1);
    run_batch(32'hFFFF_FFE0, 32'hFFFF_FF00, 32, 32'h40, 32'h80, 2, 0, 3, 1, 0);
    run_batch(32'h6000, 32'h7000, 64, 64, 64, 3, 2, 1, 0, 0);

    // Reset in the middle of a tile's WAIT.
    exp_launch_q.push_back('{32'h2000, 32'h3000, 32'd16});
    cfg_src_base = 32'h2000; cfg_dst_base = 32'h3000; cfg_tile_bytes = 16;
    cfg_src_stride = 16; cfg_dst_stride = 16; cfg_num_tiles = 4;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_start(ok);
    tick(); tick();
    areset = 1'b1;
    tick();
    chk("midrst_start", dma_ap_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_status", {batch_done, aborted, timeout_err}, 0);
    chk("midrst_tiles_done", tiles_done, 0);
    chk("midrst_ptrs", {dma_rdma_mem_ptr, dma_wdma_mem_ptr}, 0);
    chk("midrst_bytes", {dma_rdma_transfer_byte, dma_wdma_transfer_byte}, 0);
    areset = 1'b0;
    exp_stat_q.delete();
    chk("midrst_launch_consumed", exp_launch_q.size(), 0);
    run_batch(32'h2000, 32'h3000, 16, 16, 16, 2, 0, 2, 0, 0);

    for (int r = 0; r < 14; r++) begin
      int n = $urandom_range(0, 5);
      logic [AW-1:0] bytes = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 256));
      int ab = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n) : 0;
      run_batch($urandom, $urandom, bytes, $urandom, $urandom, n, ab,
                $urandom_range(1, 6), $urandom_range(0, 1) == 1, 0);
    end

    repeat (3) tick();
    chk("launch_queue_drained", exp_launch_q.size(), 0);
    chk("status_queue_drained", exp_stat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want $finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
